// File: rtl/mul_pkg.sv
// Shared types for the sequential multiplier: operand/product widths, FSM states
// and the per-step shift applied to each half-product.
package mul_pkg;

  localparam int unsigned CORE_W = 4;

  typedef logic [2*CORE_W-1:0] operand_t;
  typedef logic [4*CORE_W-1:0] product_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step order is aL*bL, aL*bH, aH*bL, aH*bH.
  function automatic int unsigned step_shift(input logic [1:0] step);
    case (step)
      2'd0:    step_shift = 0;
      2'd1:    step_shift = CORE_W;
      2'd2:    step_shift = CORE_W;
      default: step_shift = 2 * CORE_W;
    endcase
  endfunction

endpackage

// File: rtl/Mult_4_4.sv
// Combinational 4x4 unsigned multiplier core shared by all four steps
// of the sequencer.
module Mult_4_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  assign p_o = {4'b0, a_i} * {4'b0, b_i};

endmodule

// File: rtl/mul_seq_ctrl.sv
// 2W x 2W unsigned multiplier built from one W x W core, stepping the four
// half-products through it over four clocks with valid/ready on both sides.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned W = CORE_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_a,
  input  logic [2*W-1:0] in_b,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_p,
  output logic           busy
);

  state_e         state_q, state_d;
  logic [1:0]     step_q, step_d;
  logic [2*W-1:0] a_q, a_d;
  logic [2*W-1:0] b_q, b_d;
  logic [4*W-1:0] acc_q, acc_d;

  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic [2*W-1:0] core_p;
  logic [4*W-1:0] pp_ext;
  logic           accept;

  // step[1] picks the half of a, step[0] the half of b.
  assign core_a = step_q[1] ? a_q[2*W-1:W] : a_q[W-1:0];
  assign core_b = step_q[0] ? b_q[2*W-1:W] : b_q[W-1:0];

  Mult_4_4 u_core (
    .a_i (core_a),
    .b_i (core_b),
    .p_o (core_p)
  );

  assign pp_ext = {{(2*W){1'b0}}, core_p};

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready && !abort;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = acc_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (abort) begin
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = IDLE;
        end else begin
          acc_d  = acc_q + (pp_ext << step_shift(step_q));
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = IDLE;
        end else if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = MUL;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 2'd0;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and randomised checks of the sequential multiplier: latency, handshakes,
// abort, asynchronous reset and in-order results.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [15:0] out_p;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    #0;
    chk("start_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int cyc;
    out_ready = 1'b0;
    start_op(a, b);
    wait_valid(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd4);
    chk(tag, 32'(out_p), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int n_acc;
    int n_cyc;
    logic acc_now;
    logic [15:0] exp_p;
    logic [15:0] q[$];

    // Reset state
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_p",     32'(out_p),     32'd0);
    chk("rst_rdy",   32'(in_ready),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: 0xA5*0x3C, in_ready low throughout MUL even with out_ready high
    out_ready = 1'b1;
    start_op(8'hA5, 8'h3C);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rdy0", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_rdy_mul", 32'(in_ready), 32'd0);
      chk("t1_nvalid", 32'(out_valid), 32'd0);
    end
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_p", 32'(out_p), 32'h26AC);
    tick();
    chk("t1_idle_v", 32'(out_valid), 32'd0);
    chk("t1_idle_b", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // 2: extremes
    run_op("t2_ff", 8'hFF, 8'hFF, 16'hFE01);
    run_op("t2_zero", 8'h00, 8'hB7, 16'h0000);

    // 3: stall in DONE, then back-to-back accept
    start_op(8'h11, 8'h22);
    wait_valid(cyc);
    chk("t3_lat", 32'(cyc), 32'd4);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_hold_v", 32'(out_valid), 32'd1);
      chk("t3_hold_p", 32'(out_p), 32'h0242);
    end
    in_a      = 8'h12;
    in_b      = 8'h34;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #0;
    chk("t3_b2b_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t3_b2b_v", 32'(out_valid), 32'd0);
    chk("t3_b2b_busy", 32'(busy), 32'd1);
    wait_valid(cyc);
    chk("t3_b2b_lat", 32'(cyc), 32'd4);
    chk("t3_b2b_p", 32'(out_p), 32'h03A8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 4: abort in MUL step2
    start_op(8'h0F, 8'hF0);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_b", 32'(busy), 32'd0);
    chk("t4_abort_p", 32'(out_p), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_no_valid", 32'(out_valid), 32'd0);
    end
    run_op("t4_next", 8'h0F, 8'hF0, 16'h0E10);

    // abort with in_valid in IDLE: nothing accepted
    in_a     = 8'h55;
    in_b     = 8'h55;
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("idle_abort_b", 32'(busy), 32'd0);

    // abort together with out_ready in DONE: result dropped
    start_op(8'h05, 8'h07);
    wait_valid(cyc);
    chk("done_abort_pre", 32'(out_p), 32'h0023);
    abort     = 1'b1;
    out_ready = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("done_abort_v", 32'(out_valid), 32'd0);
    chk("done_abort_p", 32'(out_p), 32'd0);

    // 5: asynchronous reset mid-MUL
    start_op(8'h77, 8'h99);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_b", 32'(busy), 32'd0);
    chk("t5_rst_v", 32'(out_valid), 32'd0);
    chk("t5_rst_p", 32'(out_p), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_valid", 32'(out_valid), 32'd0);
    end
    run_op("t5_fresh", 8'h77, 8'h99, 16'h471F);

    // 6: random traffic with stalls, checked in order
    n_acc = 0;
    n_cyc = 0;
    in_valid = 1'b0;
    while ((n_acc < 2000 || q.size() != 0) && n_cyc < 60000) begin
      if (!in_valid && n_acc < 2000 && $urandom_range(3) != 0) begin
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", 32'(out_p), 32'hFFFF_FFFF);
        end else begin
          exp_p = q.pop_front();
          chk("rand", 32'(out_p), 32'(exp_p));
        end
      end
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        q.push_back(16'(in_a) * 16'(in_b));
        n_acc++;
      end
      tick();
      n_cyc++;
      if (acc_now) in_valid = 1'b0;
    end
    chk("rand_drain", 32'(q.size()), 32'd0);
    chk("rand_count", 32'(n_acc), 32'd2000);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
